// File: rtl/iob_wb_master_bridge.sv
// IOb-native subordinate to classic Wishbone initiator bridge, one transaction in flight.
// Silent targets are cut off by a bus timeout that reports through err_o.
module iob_wb_master_bridge #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                err_o,
  input  logic                err_clr_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic             accept;

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign accept      = iob_avalid_i && iob_ready_o;

  // Reset wins over cke_i; with cke_i low nothing moves and the bus is not sampled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      iob_ready_o  <= 1'b1;
      iob_rvalid_o <= 1'b0;
      iob_rdata_o  <= '0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      err_o        <= 1'b0;
    end else if (cke_i) begin
      iob_rvalid_o <= 1'b0;
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wb_adr_o    <= iob_addr_i;
            wb_dat_o    <= iob_wdata_i;
            wb_we_o     <= |iob_wstrb_i;
            wb_sel_o    <= (|iob_wstrb_i) ? iob_wstrb_i : {STRB_W{1'b1}};
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            iob_ready_o <= 1'b0;
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // ack outranks err, and a timeout only fires when the target said nothing.
          if (wb_stb_o && wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            iob_ready_o <= 1'b1;
            state       <= IDLE;
            if (!wb_we_o) begin
              iob_rdata_o  <= wb_dat_i;
              iob_rvalid_o <= 1'b1;
            end
          end else if (wb_stb_o && (wb_err_i || timeout_hit)) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            iob_ready_o <= 1'b1;
            state       <= IDLE;
            err_o       <= 1'b1;
            if (!wb_we_o) begin
              iob_rdata_o  <= ERR_RDATA;
              iob_rvalid_o <= 1'b1;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_wb_master_bridge.sv
// Bench for iob_wb_master_bridge: directed vector table, hand sequences, and random
// traffic checked against a byte-addressed reference memory.
module tb_iob_wb_master_bridge;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        clk = 1'b0;
  logic        cke_i, rst_i;
  logic        iob_avalid_i;
  logic [31:0] iob_addr_i, iob_wdata_i;
  logic [3:0]  iob_wstrb_i;
  logic        iob_rvalid_o, iob_ready_o;
  logic [31:0] iob_rdata_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic        err_o, err_clr_i;

  int testsRun = 0;
  int failures = 0;
  int overlapErrs = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;
    int          mode;
    logic [31:0] tgtData;
    logic        expRvalid;
    logic [31:0] expRdata;
    logic        expErr;
    int          expStb;
    logic        clrAfter;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] refMem[4];
  logic [31:0] slaveMem[4];

  iob_wb_master_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i       (clk),
    .cke_i       (cke_i),
    .rst_i       (rst_i),
    .iob_avalid_i(iob_avalid_i),
    .iob_addr_i  (iob_addr_i),
    .iob_wdata_i (iob_wdata_i),
    .iob_wstrb_i (iob_wstrb_i),
    .iob_rvalid_o(iob_rvalid_o),
    .iob_rdata_o (iob_rdata_o),
    .iob_ready_o (iob_ready_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (iob_ready_o === 1'b1 && wb_cyc_o === 1'b1) overlapErrs++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Entered and left at a negedge; the Wishbone target is played inline here.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int waits, input int mode,
                               input logic [31:0] tgtData,
                               output int stbCnt, output logic gotRvalid,
                               output logic [31:0] gotRdata, output logic [31:0] capAdr,
                               output logic [31:0] capDat, output logic [3:0] capSel,
                               output logic capWe, output logic timedOut);
    iob_avalid_i = 1'b1;
    iob_addr_i   = addr;
    iob_wdata_i  = wdata;
    iob_wstrb_i  = wstrb;
    @(negedge clk);
    iob_avalid_i = 1'b0;
    capAdr = wb_adr_o;
    capDat = wb_dat_o;
    capSel = wb_sel_o;
    capWe  = wb_we_o;
    checkOutput("busy_ready_low", {63'd0, iob_ready_o}, 64'd0);
    checkOutput("rvalid_pulse_end", {63'd0, iob_rvalid_o}, 64'd0);
    stbCnt    = 0;
    gotRvalid = 1'b0;
    gotRdata  = '0;
    timedOut  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (!wb_stb_o) begin
        gotRvalid = iob_rvalid_o;
        gotRdata  = iob_rdata_o;
        timedOut  = 1'b0;
        break;
      end
      stbCnt++;
      wb_ack_i = ((mode == M_ACK) || (mode == M_BOTH)) && (c == waits);
      wb_err_i = ((mode == M_ERR) || (mode == M_BOTH)) && (c == waits);
      wb_dat_i = tgtData;
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  endtask

  int          stbCnt;
  logic        gotRvalid, capWe, timedOut;
  logic [31:0] gotRdata, capAdr, capDat;
  logic [3:0]  capSel;

  initial begin
    vecs[0] = '{32'h0C, 32'h0000001B, 4'b0001, 1, M_ACK,  32'h0,        1'b0, 32'h0,        1'b0, 2, 1'b0};
    vecs[1] = '{32'h00, 32'h0,        4'b0000, 0, M_ACK,  32'h00000081, 1'b1, 32'h00000081, 1'b0, 1, 1'b0};
    vecs[2] = '{32'h04, 32'h0,        4'b0000, 0, M_ACK,  32'h00000042, 1'b1, 32'h00000042, 1'b0, 1, 1'b0};
    vecs[3] = '{32'h08, 32'h0,        4'b0000, 0, M_NONE, 32'h11111111, 1'b1, 32'hDEADBEEF, 1'b1, 4, 1'b1};
    vecs[4] = '{32'h10, 32'h0000005A, 4'b1111, 0, M_ERR,  32'h0,        1'b0, 32'h0,        1'b1, 1, 1'b0};
    vecs[5] = '{32'h14, 32'h0,        4'b0000, 0, M_BOTH, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 1, 1'b1};
    vecs[6] = '{32'h18, 32'hA5A5A5A5, 4'b0110, 3, M_ACK,  32'h0,        1'b0, 32'h0,        1'b0, 4, 1'b0};
    vecs[7] = '{32'h1C, 32'h0,        4'b0000, 3, M_ACK,  32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0, 4, 1'b0};

    rst_i = 1'b1; cke_i = 1'b1; iob_avalid_i = 1'b0; iob_addr_i = '0; iob_wdata_i = '0;
    iob_wstrb_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; err_clr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      refMem[i] = '0;
      slaveMem[i] = '0;
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {63'd0, iob_ready_o}, 64'd1);
    checkOutput("rst_rvalid", {63'd0, iob_rvalid_o}, 64'd0);
    checkOutput("rst_rdata", {32'd0, iob_rdata_o}, 64'd0);
    checkOutput("rst_cyc_stb_we", {61'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 64'd0);
    checkOutput("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'd0);
    checkOutput("rst_sel_err", {59'd0, wb_sel_o, err_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].waits, vecs[i].mode,
                    vecs[i].tgtData, stbCnt, gotRvalid, gotRdata, capAdr, capDat, capSel,
                    capWe, timedOut);
      checkOutput($sformatf("v%0d_done", i), {63'd0, timedOut}, 64'd0);
      checkOutput($sformatf("v%0d_adr", i), {32'd0, capAdr}, {32'd0, vecs[i].addr});
      checkOutput($sformatf("v%0d_dat", i), {32'd0, capDat}, {32'd0, vecs[i].wdata});
      checkOutput($sformatf("v%0d_we", i), {63'd0, capWe}, {63'd0, vecs[i].wstrb != 4'd0});
      checkOutput($sformatf("v%0d_sel", i), {60'd0, capSel},
                  {60'd0, (vecs[i].wstrb == 4'd0) ? 4'hF : vecs[i].wstrb});
      checkOutput($sformatf("v%0d_stb_cycles", i), 64'(stbCnt), 64'(vecs[i].expStb));
      checkOutput($sformatf("v%0d_rvalid", i), {63'd0, gotRvalid}, {63'd0, vecs[i].expRvalid});
      if (vecs[i].expRvalid)
        checkOutput($sformatf("v%0d_rdata", i), {32'd0, gotRdata}, {32'd0, vecs[i].expRdata});
      checkOutput($sformatf("v%0d_err", i), {63'd0, err_o}, {63'd0, vecs[i].expErr});
      checkOutput($sformatf("v%0d_ready", i), {63'd0, iob_ready_o}, 64'd1);
      if (vecs[i].clrAfter) begin
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        checkOutput($sformatf("v%0d_err_clr", i), {63'd0, err_o}, 64'd0);
      end
    end

    // Clear held across a timeout: the set on the final edge must win.
    err_clr_i = 1'b1;
    applyStimulus(32'h20, 32'h0, 4'b0000, 0, M_NONE, 32'h0, stbCnt, gotRvalid, gotRdata,
                  capAdr, capDat, capSel, capWe, timedOut);
    err_clr_i = 1'b0;
    checkOutput("setclr_err", {63'd0, err_o}, 64'd1);
    checkOutput("setclr_rdata", {32'd0, gotRdata}, 64'hDEADBEEF);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;

    // Clock-enable stall with ack already asserted.
    iob_avalid_i = 1'b1; iob_addr_i = 32'h24; iob_wstrb_i = 4'b0000;
    @(negedge clk);
    iob_avalid_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h00000077; cke_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_stb_rvalid_ready", k),
                  {61'd0, wb_stb_o, iob_rvalid_o, iob_ready_o}, 64'b100);
    end
    cke_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    checkOutput("stall_release_stb", {63'd0, wb_stb_o}, 64'd0);
    checkOutput("stall_release_rvalid", {63'd0, iob_rvalid_o}, 64'd1);
    checkOutput("stall_release_rdata", {32'd0, iob_rdata_o}, 64'h77);

    // Reset in the middle of a read, followed by a late ack.
    @(negedge clk);
    iob_avalid_i = 1'b1; iob_addr_i = 32'h28; iob_wstrb_i = 4'b0000;
    @(negedge clk);
    iob_avalid_i = 1'b0;
    checkOutput("midrst_pre_stb", {63'd0, wb_stb_o}, 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    checkOutput("midrst_cyc_stb", {62'd0, wb_cyc_o, wb_stb_o}, 64'd0);
    checkOutput("midrst_ready_rvalid", {62'd0, iob_ready_o, iob_rvalid_o}, 64'b10);
    wb_ack_i = 1'b1; wb_dat_i = 32'h00000099;
    @(negedge clk);
    wb_ack_i = 1'b0;
    checkOutput("late_ack_rvalid", {63'd0, iob_rvalid_o}, 64'd0);
    checkOutput("late_ack_rdata", {32'd0, iob_rdata_o}, 64'd0);
    checkOutput("late_ack_stb", {63'd0, wb_stb_o}, 64'd0);

    // Random alternating writes/reads with 0-3 wait states against a memory.
    for (int n = 0; n < 16; n++) begin
      int          idx;
      int          waits;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      idx   = $urandom_range(0, 3);
      waits = $urandom_range(0, 3);
      wdata = $urandom;
      wstrb = (n % 2 == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      applyStimulus(32'(idx * 4), wdata, wstrb, waits, M_ACK, slaveMem[idx], stbCnt,
                    gotRvalid, gotRdata, capAdr, capDat, capSel, capWe, timedOut);
      checkOutput($sformatf("rnd%0d_done", n), {63'd0, timedOut}, 64'd0);
      checkOutput($sformatf("rnd%0d_stb_cycles", n), 64'(stbCnt), 64'(waits + 1));
      if (wstrb != 4'd0) begin
        refMem[idx]   = mergeBytes(refMem[idx], wdata, wstrb);
        slaveMem[idx] = mergeBytes(slaveMem[idx], capDat, capSel);
        checkOutput($sformatf("rnd%0d_w_norvalid", n), {63'd0, gotRvalid}, 64'd0);
      end else begin
        checkOutput($sformatf("rnd%0d_r_rvalid", n), {63'd0, gotRvalid}, 64'd1);
        checkOutput($sformatf("rnd%0d_r_data", n), {32'd0, gotRdata}, {32'd0, refMem[idx]});
      end
    end
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("mem%0d_final", i), {32'd0, slaveMem[i]}, {32'd0, refMem[i]});
    checkOutput("final_err", {63'd0, err_o}, 64'd0);

    @(negedge clk);
    checkOutput("ready_cyc_overlap", 64'(overlapErrs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
